// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared types and sizing for the 4x8 register file and its front-end arbiter.
//   state_t : arbiter sequencer states (idle, issue to regfile, completion)
//   RF_DW   : register data width
//   RF_AW   : register address width (4 registers)
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int RF_DW = 8;
    localparam int RF_AW = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/regfile.sv
// -----------------------------------------------------------------------------
// regfile
// 4x8 register file: one synchronous write port, one combinational read port.
//   ck      : clock, rising edge
//   we      : write enable
//   din     : write data
//   inaddr  : write address
//   outaddr : read address
//   dout    : read data (combinational)
// Storage has no reset so contents survive an arbiter reset.
// -----------------------------------------------------------------------------
module regfile
    import regfile_pkg::*;
#(
    parameter int DW = RF_DW,
    parameter int AW = RF_AW
) (
    input  logic          ck,
    input  logic          we,
    input  logic [DW-1:0] din,
    input  logic [AW-1:0] inaddr,
    input  logic [AW-1:0] outaddr,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] r_mem [2**AW];

    // Write port
    always_ff @(posedge ck) begin
        if (we) begin
            r_mem[inaddr] <= din;
        end
    end

    assign dout = r_mem[outaddr];

endmodule

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way pick. Bit 0 is requester A, bit 1 is requester B.
//   i_req  : request vector
//   i_prio : preferred requester when both ask (0 = A, 1 = B)
//   o_gnt  : one-hot winner, all-zero when nobody asks
// The priority pointer itself lives in the parent.
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_prio,
    output logic [1:0] o_gnt
);

    // Winner selection; prio only matters on a tie
    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11: begin
                if (i_prio) begin
                    o_gnt = 2'b10;
                end else begin
                    o_gnt = 2'b01;
                end
            end
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/regfile_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_arbiter
// Round-robin front end sharing the regfile's single read and write port
// between masters A and B. One operation per grant, two cycles per operation.
//   ck, rst_n                  : clock, async active-low reset
//   req_*/wr_*/addr_*/wdata_*  : per-master request and operands
//   gnt_*                      : one-cycle grant (high during the ISSUE cycle)
//   done_*                     : one-cycle completion (high during DONE)
//   rdata                      : last read result, held until the next read
//   rf_we/rf_din/rf_inaddr/rf_outaddr : driven into the regfile
//   rf_dout                    : regfile combinational read data
// -----------------------------------------------------------------------------
module regfile_arbiter
    import regfile_pkg::*;
#(
    parameter int DW = RF_DW,
    parameter int AW = RF_AW
) (
    input  logic          ck,
    input  logic          rst_n,
    input  logic          req_a,
    input  logic          req_b,
    input  logic          wr_a,
    input  logic          wr_b,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_a,
    input  logic [DW-1:0] wdata_b,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          done_a,
    output logic          done_b,
    output logic [DW-1:0] rdata,
    output logic          rf_we,
    output logic [DW-1:0] rf_din,
    output logic [AW-1:0] rf_inaddr,
    output logic [AW-1:0] rf_outaddr,
    input  logic [DW-1:0] rf_dout
);

    state_t        r_state;
    logic          r_prio;
    logic          r_wr;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_owner;     // 0 = A, 1 = B
    logic [1:0]    w_win;

    rr_arb2 u_arb (
        .i_req  ({req_b, req_a}),
        .i_prio (r_prio),
        .o_gnt  (w_win)
    );

    // Sequencer: arbitrate in IDLE/DONE, issue one cycle, then report completion
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_prio  <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= {AW{1'b0}};
            r_wdata <= {DW{1'b0}};
            r_owner <= 1'b0;
            gnt_a   <= 1'b0;
            gnt_b   <= 1'b0;
            done_a  <= 1'b0;
            done_b  <= 1'b0;
            rdata   <= {DW{1'b0}};
        end else begin
            gnt_a  <= 1'b0;
            gnt_b  <= 1'b0;
            done_a <= 1'b0;
            done_b <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_win != 2'b00) begin
                        r_wr    <= w_win[1] ? wr_b    : wr_a;
                        r_addr  <= w_win[1] ? addr_b  : addr_a;
                        r_wdata <= w_win[1] ? wdata_b : wdata_a;
                        r_owner <= w_win[1];
                        gnt_a   <= w_win[0];
                        gnt_b   <= w_win[1];
                        // Hand preference to whoever did not just win
                        r_prio  <= w_win[0];
                        r_state <= ST_ISSUE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    // Requests are ignored here; the regfile write commits on this edge
                    if (!r_wr) begin
                        rdata <= rf_dout;
                    end
                    done_a  <= ~r_owner;
                    done_b  <= r_owner;
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Decoded from state so an async reset drops the write strobe at once
    assign rf_we      = (r_state == ST_ISSUE) && r_wr;
    assign rf_din     = r_wdata;
    assign rf_inaddr  = r_addr;
    assign rf_outaddr = r_addr;

endmodule

// File: tb/tb_regfile_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_arbiter
// Arbiter plus regfile under directed and randomized operations. Expected
// grants, completions and read data come from a transaction-level model:
// a round-robin preference bit, a 4-entry memory array and the last read value.
// -----------------------------------------------------------------------------
module tb_regfile_arbiter;

    logic       ck;
    logic       rst_n;
    logic       req_a, req_b;
    logic       wr_a, wr_b;
    logic [1:0] addr_a, addr_b;
    logic [7:0] wdata_a, wdata_b;
    logic       gnt_a, gnt_b, done_a, done_b;
    logic [7:0] rdata;
    logic       rf_we;
    logic [7:0] rf_din;
    logic [1:0] rf_inaddr, rf_outaddr;
    logic [7:0] rf_dout;

    // Operands per requester (index 0 = A, 1 = B)
    logic       op_wr   [2];
    logic [1:0] op_addr [2];
    logic [7:0] op_data [2];

    // Reference model
    logic [7:0] m_mem   [4];
    logic       m_valid [4];
    logic [7:0] m_rdata;
    logic       m_prio;

    int n_tests;
    int n_fail;

    assign wr_a    = op_wr[0];
    assign wr_b    = op_wr[1];
    assign addr_a  = op_addr[0];
    assign addr_b  = op_addr[1];
    assign wdata_a = op_data[0];
    assign wdata_b = op_data[1];

    regfile_arbiter #(.DW(8), .AW(2)) dut (
        .ck(ck), .rst_n(rst_n),
        .req_a(req_a), .req_b(req_b), .wr_a(wr_a), .wr_b(wr_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
        .rdata(rdata), .rf_we(rf_we), .rf_din(rf_din),
        .rf_inaddr(rf_inaddr), .rf_outaddr(rf_outaddr), .rf_dout(rf_dout)
    );

    regfile #(.DW(8), .AW(2)) u_rf (
        .ck(ck), .we(rf_we), .din(rf_din),
        .inaddr(rf_inaddr), .outaddr(rf_outaddr), .dout(rf_dout)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge ck);
        #1;
    endtask

    task automatic set_op(input int who, input logic wr, input logic [1:0] a, input logic [7:0] d);
        op_wr[who]   = wr;
        op_addr[who] = a;
        op_data[who] = d;
    endtask

    task automatic set_req(input int who, input logic v);
        if (who == 0) req_a = v;
        else          req_b = v;
    endtask

    task automatic quiet_check(input string tag);
        chk({tag, "_gnt_a"}, gnt_a, 1'b0);
        chk({tag, "_gnt_b"}, gnt_b, 1'b0);
        chk({tag, "_done_a"}, done_a, 1'b0);
        chk({tag, "_done_b"}, done_b, 1'b0);
        chk({tag, "_rf_we"}, rf_we, 1'b0);
    endtask

    // Cycle after the arbitration edge: the granted operation is on the rf_* pins
    task automatic grant_phase(input int who);
        cyc();
        chk("gnt_a", gnt_a, (who == 0));
        chk("gnt_b", gnt_b, (who == 1));
        chk("issue_we", rf_we, op_wr[who]);
        chk("issue_inaddr", rf_inaddr, op_addr[who]);
        chk("issue_outaddr", rf_outaddr, op_addr[who]);
        chk("issue_din", rf_din, op_data[who]);
        chk("issue_done", {done_a, done_b}, 2'b00);
        m_prio = (who == 0);
    endtask

    // Completion cycle: done for the owner, read data from the model memory
    task automatic done_phase(input int who, input logic drop);
        cyc();
        if (op_wr[who]) begin
            m_mem[op_addr[who]]   = op_data[who];
            m_valid[op_addr[who]] = 1'b1;
        end else begin
            m_rdata = m_mem[op_addr[who]];
        end
        chk("done_a", done_a, (who == 0));
        chk("done_b", done_b, (who == 1));
        chk("done_gnt", {gnt_a, gnt_b}, 2'b00);
        chk("done_we", rf_we, 1'b0);
        chk("rdata", rdata, m_rdata);
        if (drop) set_req(who, 1'b0);
    endtask

    task automatic single(input int who);
        set_req(who, 1'b1);
        grant_phase(who);
        done_phase(who, 1'b1);
    endtask

    task automatic pair();
        int w;
        req_a = 1'b1;
        req_b = 1'b1;
        w = m_prio ? 1 : 0;
        grant_phase(w);
        done_phase(w, 1'b1);
        grant_phase(1 - w);
        done_phase(1 - w, 1'b1);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        m_prio  = 1'b0;
        m_rdata = 8'h00;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        for (int i = 0; i < 2; i++) set_op(i, 1'b0, 2'd0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            m_mem[i]   = 8'h00;
            m_valid[i] = 1'b0;
        end
        m_rdata = 8'h00;
        m_prio  = 1'b0;

        // Reset values
        cyc();
        cyc();
        quiet_check("rst");
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_din", rf_din, 8'h00);
        chk("rst_inaddr", rf_inaddr, 2'd0);
        chk("rst_outaddr", rf_outaddr, 2'd0);
        rst_n = 1'b1;
        cyc();

        // A writes 2 = 5A, then reads it back
        set_op(0, 1'b1, 2'd2, 8'h5A);
        single(0);
        set_op(0, 1'b0, 2'd2, 8'h00);
        single(0);
        chk("rd_5a", rdata, 8'h5A);

        // Simultaneous writes after reset: A first, B two cycles later
        reset_pulse();
        set_op(0, 1'b1, 2'd0, 8'h11);
        set_op(1, 1'b1, 2'd1, 8'h22);
        pair();
        set_op(0, 1'b0, 2'd0, 8'h00);
        single(0);
        chk("rd_11", rdata, 8'h11);
        set_op(1, 1'b0, 2'd1, 8'h00);
        single(1);
        chk("rd_22", rdata, 8'h22);

        // Fairness: both held for 6 grants
        set_op(0, 1'b0, 2'd0, 8'h00);
        set_op(1, 1'b0, 2'd1, 8'h00);
        req_a = 1'b1;
        req_b = 1'b1;
        for (int g = 0; g < 6; g++) begin
            int w;
            w = m_prio ? 1 : 0;
            grant_phase(w);
            done_phase(w, 1'b0);
        end
        req_a = 1'b0;
        req_b = 1'b0;
        cyc();
        quiet_check("fair_end");

        // Read after write: B writes 3 = 04, A reads 3 in the next grant
        if (m_prio == 1'b0) begin
            set_op(0, 1'b0, 2'd0, 8'h00);
            single(0);
        end
        set_op(1, 1'b1, 2'd3, 8'h04);
        set_op(0, 1'b0, 2'd3, 8'h00);
        pair();
        chk("raw_rd", rdata, 8'h04);

        // Reset during ISSUE of a write of FF to address 1
        set_op(0, 1'b1, 2'd1, 8'hFF);
        req_a = 1'b1;
        cyc();
        chk("mid_we_before", rf_we, 1'b1);
        rst_n = 1'b0;
        #1;
        quiet_check("mid_rst");
        chk("mid_rdata", rdata, 8'h00);
        chk("mid_din", rf_din, 8'h00);
        chk("mid_inaddr", rf_inaddr, 2'd0);
        chk("mid_outaddr", rf_outaddr, 2'd0);
        req_a = 1'b0;
        cyc();
        cyc();
        quiet_check("mid_hold");
        rst_n = 1'b1;
        m_prio  = 1'b0;
        m_rdata = 8'h00;
        cyc();
        quiet_check("mid_post");
        set_op(0, 1'b0, 2'd1, 8'h00);
        single(0);
        chk("mid_rd_22", rdata, 8'h22);

        // Idle for 10 cycles
        for (int k = 0; k < 10; k++) begin
            cyc();
            quiet_check("idle");
        end

        // Randomized mix of single and simultaneous operations
        for (int it = 0; it < 40; it++) begin
            int mask;
            mask = $urandom_range(1, 3);
            for (int r = 0; r < 2; r++) begin
                logic       wr;
                logic [1:0] a;
                wr = 1'($urandom_range(0, 1));
                a  = 2'($urandom_range(0, 3));
                if (!wr && !m_valid[a]) wr = 1'b1;
                set_op(r, wr, a, 8'($urandom_range(0, 255)));
            end
            if (mask == 3)      pair();
            else if (mask == 1) single(0);
            else                single(1);
            repeat ($urandom_range(0, 2)) begin
                cyc();
                quiet_check("gap");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
